// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode constants, load-opcode list and controller state encodings.
package pipe_ctrl_pkg;

  localparam int unsigned OP_W  = 6;
  localparam int unsigned REG_W = 5;

  localparam logic [OP_W-1:0] OP_SPECIAL = 6'h00;
  localparam logic [OP_W-1:0] OP_ADDI    = 6'h08;
  localparam logic [OP_W-1:0] OP_LB      = 6'h20;
  localparam logic [OP_W-1:0] OP_LH      = 6'h21;
  localparam logic [OP_W-1:0] OP_LW      = 6'h23;
  localparam logic [OP_W-1:0] OP_LBU     = 6'h24;
  localparam logic [OP_W-1:0] OP_LHU     = 6'h25;
  localparam logic [OP_W-1:0] OP_SW      = 6'h2b;

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  // True for every opcode whose result only exists after the Memory stage.
  function automatic logic is_load(input logic [OP_W-1:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: is_load = 1'b1;
      default:                             is_load = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipe_ctrl.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic [REG_W-1:0] D_srcA;
  logic [REG_W-1:0] D_srcB;
  logic             D_md_use;
  logic [OP_W-1:0]  E_op;
  logic [REG_W-1:0] E_dstM;
  logic             E_mispredict;
  logic             E_md_start;
  logic             E_md_div;
  logic             M_mem_req;
  logic             dmem_ready;

  logic             F_stall;
  logic             D_stall;
  logic             E_stall;
  logic             M_stall;
  logic             D_bubble;
  logic             E_bubble;
  logic             M_bubble;
  logic             W_bubble;
  logic             md_busy;
  logic             mem_err;

  modport master (
    output D_srcA, D_srcB, D_md_use, E_op, E_dstM, E_mispredict,
           E_md_start, E_md_div, M_mem_req, dmem_ready,
    input  F_stall, D_stall, E_stall, M_stall,
           D_bubble, E_bubble, M_bubble, W_bubble, md_busy, mem_err
  );

  modport slave (
    input  D_srcA, D_srcB, D_md_use, E_op, E_dstM, E_mispredict,
           E_md_start, E_md_div, M_mem_req, dmem_ready,
    output F_stall, D_stall, E_stall, M_stall,
           D_bubble, E_bubble, M_bubble, W_bubble, md_busy, mem_err
  );

endinterface

// File: rtl/md_timer.sv
// Multiply/divide latency counter: loads a latency, counts down to zero.
module md_timer #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] latency,
  output logic             busy
);

  logic [CNT_W-1:0] cnt_q;

  // Reload on start, otherwise count down every cycle regardless of stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= latency;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stall/bubble generation for memory waits,
// mispredicts, load-use and multiply/divide hazards.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MUL_CYCLES  = 5,
  parameter int unsigned DIV_CYCLES  = 33,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  pipe_ctrl_if.slave bus
);

  localparam int unsigned MD_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned MD_W   = $clog2(MD_MAX + 1);
  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic              mem_err_q;

  logic wait_start_c, wait_inc_c, wait_clr_c, err_set_c, free_c;
  logic f_stall_c, d_stall_c, e_stall_c, m_stall_c;
  logic d_bubble_c, e_bubble_c, m_bubble_c, w_bubble_c;
  logic load_use_c, md_haz_c, mem_pend_c, timeout_c, md_load_c, md_busy;
  logic [MD_W-1:0] md_latency_c;

  // Hazard detection on the current Decode/Execute/Memory contents.
  assign load_use_c = is_load(bus.E_op) && (bus.E_dstM != '0) &&
                      ((bus.E_dstM == bus.D_srcA) || (bus.E_dstM == bus.D_srcB));
  assign md_haz_c   = bus.D_md_use && (md_busy || bus.E_md_start);
  assign mem_pend_c = bus.M_mem_req && !bus.dmem_ready;
  assign timeout_c  = (wait_cnt_q == WAIT_W'(MEM_TIMEOUT));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and stall/bubble outputs; memory wait outranks everything,
  // mispredict outranks the Decode-side hazards.
  always_comb begin
    state_d      = state_q;
    f_stall_c    = 1'b0;
    d_stall_c    = 1'b0;
    e_stall_c    = 1'b0;
    m_stall_c    = 1'b0;
    d_bubble_c   = 1'b0;
    e_bubble_c   = 1'b0;
    m_bubble_c   = 1'b0;
    w_bubble_c   = 1'b0;
    wait_start_c = 1'b0;
    wait_inc_c   = 1'b0;
    wait_clr_c   = 1'b0;
    err_set_c    = 1'b0;
    free_c       = 1'b0;

    case (state_q)
      ST_INIT: begin
        // Pipeline registers have no reset: flush them once.
        d_bubble_c = 1'b1;
        e_bubble_c = 1'b1;
        m_bubble_c = 1'b1;
        w_bubble_c = 1'b1;
        wait_clr_c = 1'b1;
        state_d    = ST_RUN;
      end
      ST_RUN: begin
        if (mem_pend_c) begin
          f_stall_c    = 1'b1;
          d_stall_c    = 1'b1;
          e_stall_c    = 1'b1;
          m_stall_c    = 1'b1;
          w_bubble_c   = 1'b1;
          wait_start_c = 1'b1;
          state_d      = ST_MEM_WAIT;
        end else begin
          free_c = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_pend_c && !timeout_c) begin
          f_stall_c  = 1'b1;
          d_stall_c  = 1'b1;
          e_stall_c  = 1'b1;
          m_stall_c  = 1'b1;
          w_bubble_c = 1'b1;
          wait_inc_c = 1'b1;
        end else begin
          // Ready or timed out: release this cycle.
          err_set_c  = mem_pend_c;
          wait_clr_c = 1'b1;
          free_c     = 1'b1;
          state_d    = ST_RUN;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    if (free_c) begin
      if (bus.E_mispredict) begin
        d_bubble_c = 1'b1;
        e_bubble_c = 1'b1;
      end else if (load_use_c || md_haz_c) begin
        f_stall_c  = 1'b1;
        d_stall_c  = 1'b1;
        e_bubble_c = 1'b1;
      end
    end
  end

  // Memory-wait cycle counter; the entry cycle counts as the first wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else if (wait_clr_c) begin
      wait_cnt_q <= '0;
    end else if (wait_start_c) begin
      wait_cnt_q <= WAIT_W'(1);
    end else if (wait_inc_c) begin
      wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
    end
  end

  // Sticky memory-timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_err_q <= 1'b0;
    end else if (err_set_c) begin
      mem_err_q <= 1'b1;
    end
  end

  // Start only when the Execute instruction really advances.
  assign md_load_c    = bus.E_md_start && !e_stall_c && (state_q != ST_INIT);
  assign md_latency_c = bus.E_md_div ? MD_W'(DIV_CYCLES) : MD_W'(MUL_CYCLES);

  md_timer #(
    .CNT_W(MD_W)
  ) u_md_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (md_load_c),
    .latency (md_latency_c),
    .busy    (md_busy)
  );

  assign bus.F_stall  = f_stall_c;
  assign bus.D_stall  = d_stall_c;
  assign bus.E_stall  = e_stall_c;
  assign bus.M_stall  = m_stall_c;
  assign bus.D_bubble = d_bubble_c;
  assign bus.E_bubble = e_bubble_c;
  assign bus.M_bubble = m_bubble_c;
  assign bus.W_bubble = w_bubble_c;
  assign bus.md_busy  = md_busy;
  assign bus.mem_err  = mem_err_q;

endmodule
